// File: rtl/signed_mult_inv_sqrt2_seq.sv
// rtl/signed_mult_inv_sqrt2_seq.sv - sequential shift-add multiplier by 1/sqrt(2)
// One bit of K = 16'hB505 is applied per clock; p = floor(a*K / 2^16).
module signed_mult_inv_sqrt2_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] p
);

  localparam logic [15:0] K = 16'hB505;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nxt;
  logic signed [N+15:0]  opa;
  logic signed [N+16:0]  acc;
  logic signed [N+16:0]  addend;
  logic [3:0]            cnt;
  logic                  accept;

  assign accept = in_valid & in_ready;

  // N+17 bits keep -2^(N-1)*K clear of overflow
  assign addend = $signed({opa[N+15], opa}) <<< cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (cnt == 4'd15) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    p         = acc[N+15:16];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      opa <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa <= {{16{a[N-1]}}, a};
            acc <= '0;
            cnt <= '0;
          end
        end
        BUSY: begin
          if (K[cnt]) acc <= acc + addend;
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mult_inv_sqrt2_seq.sv
// tb/tb_signed_mult_inv_sqrt2_seq.sv - directed bench for the 1/sqrt(2) multiplier
// Drives on negedge, samples on negedge after the active posedge.
module tb_signed_mult_inv_sqrt2_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [7:0]  a = '0;
  logic        in_ready, out_valid;
  logic [7:0]  p;

  logic        in_valid16 = 1'b0, flush16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] a16 = '0;
  logic        in_ready16, out_valid16;
  logic [15:0] p16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  signed_mult_inv_sqrt2_seq #(.N(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  signed_mult_inv_sqrt2_seq #(.N(16)) dut16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16),
    .flush(flush16), .out_valid(out_valid16), .out_ready(out_ready16), .p(p16)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic signed [31:0] model(input logic signed [31:0] v);
    longint m;
    m = (longint'(v) * 64'sd46341) >>> 16;
    return m[31:0];
  endfunction

  // Issue one operand to the N=8 engine; lat counts the accept cycle as 1.
  task automatic start8(input logic signed [7:0] v);
    int w;
    w = 0;
    in_valid = 1'b1;
    a = v;
    while (!in_ready && w < 40) begin step(); w++; end
    if (w >= 40) chk("accept8_timeout", 32'sd0, 32'sd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run8(input logic signed [7:0] v, output logic signed [7:0] res,
                      output int lat);
    start8(v);
    lat = 1;
    while (!out_valid && lat < 40) begin step(); lat++; end
    res = p;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run16(input logic signed [15:0] v, output logic signed [15:0] res);
    int w;
    w = 0;
    in_valid16 = 1'b1;
    a16 = v;
    while (!in_ready16 && w < 40) begin step(); w++; end
    step();
    in_valid16 = 1'b0;
    w = 0;
    while (!out_valid16 && w < 40) begin step(); w++; end
    if (w >= 40) chk("done16_timeout", 32'sd0, 32'sd1);
    res = p16;
    out_ready16 = 1'b1;
    step();
    out_ready16 = 1'b0;
  endtask

  logic signed [7:0]  r8;
  logic signed [15:0] r16;
  logic signed [15:0] v16;
  int lat;
  int ovseen;

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'sd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'sd0);
    chk("rst_p", $signed(p), 32'sd0);
    step();
    rstn = 1'b1;
    step();

    // asynchronous reset in the middle of BUSY
    start8(8'sd100);
    repeat (5) step();
    chk("busy_in_ready", {31'd0, in_ready}, 32'sd0);
    rstn = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'sd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'sd0);
    chk("midrst_p", $signed(p), 32'sd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // basic products and latency
    run8(8'sd100, r8, lat);
    chk("p_100", $signed(r8), 32'sd70);
    chk("lat_100", lat, 32'sd17);
    run8(-8'sd100, r8, lat);
    chk("p_m100", $signed(r8), -32'sd71);
    chk("lat_m100", lat, 32'sd17);

    // extremes
    run8(8'sd127, r8, lat);  chk("p_127", $signed(r8), 32'sd89);
    run8(-8'sd128, r8, lat); chk("p_m128", $signed(r8), -32'sd91);
    run8(8'sd0, r8, lat);    chk("p_0", $signed(r8), 32'sd0);
    run8(8'sd1, r8, lat);    chk("p_1", $signed(r8), 32'sd0);
    run8(-8'sd1, r8, lat);   chk("p_m1", $signed(r8), -32'sd1);

    // backpressure in DONE, with a competing operand offered upstream
    start8(8'sd50);
    lat = 1;
    while (!out_valid && lat < 40) begin step(); lat++; end
    chk("bp_lat", lat, 32'sd17);
    in_valid = 1'b1;
    a = 8'sd11;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_out_valid", {31'd0, out_valid}, 32'sd1);
      chk("bp_p", $signed(p), 32'sd35);
      chk("bp_in_ready", {31'd0, in_ready}, 32'sd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_rel_out_valid", {31'd0, out_valid}, 32'sd0);
    chk("bp_rel_in_ready", {31'd0, in_ready}, 32'sd1);
    run8(-8'sd50, r8, lat);
    chk("p_m50_after_bp", $signed(r8), -32'sd36);
    chk("lat_m50", lat, 32'sd17);

    // flush at cnt==7 with a new operand offered in the same cycle
    start8(8'sd77);
    repeat (7) step();
    flush = 1'b1;
    in_valid = 1'b1;
    a = 8'sd33;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'sd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'sd0);
    ovseen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) ovseen++;
      step();
    end
    chk("flush_no_result", ovseen, 32'sd0);
    chk("flush_idle_after", {31'd0, in_ready}, 32'sd1);

    // flush in IDLE beats in_valid
    flush = 1'b1;
    in_valid = 1'b1;
    a = 8'sd5;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle_no_accept", {31'd0, in_ready}, 32'sd1);
    run8(8'sd33, r8, lat);
    chk("p_33_after_flush", $signed(r8), 32'sd23);

    // exhaustive N=8 sweep
    for (int i = -128; i < 128; i++) begin
      run8(i[7:0], r8, lat);
      chk("sweep8", $signed(r8), model(i));
    end

    // N=16: corners plus random operands
    run16(16'sh7FFF, r16); chk("p16_max", $signed(r16), model(32'sd32767));
    run16(16'sh8000, r16); chk("p16_min", $signed(r16), model(-32'sd32768));
    for (int i = 0; i < 20; i++) begin
      v16 = 16'($urandom);
      run16(v16, r16);
      chk("rand16", $signed(r16), model(32'($signed(v16))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
